soc_bus_arbiter: RTL
====================

// Module: soc_bus_arbiter
// PURPOSE
//   N-way round-robin arbiter that shares one peripheral slave (the GPIO register block in soc_top)
//   between several bus requesters, e.g. the PicoRV32 CPU and a debug/DMA master.
//   Requester and slave sides both use the PicoRV32 native memory handshake (valid/ready, addr,
//   wdata, wstrb, rdata). A bus-timeout watchdog completes hung transfers with an error word.
// PARAMETERS
//   NUM_REQ   2              number of requesters (>=2)
//   TIMEOUT   16             BUSY cycles before forced completion; 0 disables the watchdog
//   ERR_DATA  32'hBAD0_BAD0  rdata returned on timeout
// PORTS
//   clk          in   1           system clock, all logic on rising edge
//   reset        in   1           synchronous, active-high reset
//   m_valid      in   NUM_REQ     per-requester request; held with fields stable until m_ready
//   m_ready      out  NUM_REQ     per-requester completion pulse (one-hot or zero)
//   m_addr       in   NUM_REQ*32  packed addresses, requester i at [32*i +: 32]
//   m_wdata      in   NUM_REQ*32  packed write data
//   m_wstrb      in   NUM_REQ*4   packed byte strobes; 0 = read
//   m_rdata      out  32          broadcast read data; meaningful only when an m_ready bit is 1
//   s_valid      out  1           request to slave
//   s_ready      in   1           slave completion
//   s_addr       out  32          muxed address of granted requester
//   s_wdata      out  32          muxed write data
//   s_wstrb      out  4           muxed strobes
//   s_rdata      in   32          slave read data, valid with s_ready
//   grant        out  NUM_REQ     one-hot owner, registered; 0 when idle
//   timeout_err  out  1           one-cycle pulse when the watchdog fires
// BEHAVIOUR
//   - Reset: state=IDLE, grant=0, last-winner pointer=NUM_REQ-1 (requester 0 wins first),
//     timeout counter=0; s_valid=0, m_ready=0, timeout_err=0, s_* buses=0.
//   - FSM states: IDLE, BUSY.
//   - IDLE: if any m_valid, pick first set bit searching from pointer+1 with wrap-around;
//     register grant, clear counter, go BUSY. At least one IDLE cycle between transfers.
//   - Latency: m_valid seen in IDLE at cycle t -> grant and s_valid high at t+1.
//   - BUSY: s_valid=1; s_addr/s_wdata/s_wstrb combinationally muxed from the granted requester's
//     live inputs. Non-granted requesters see m_ready=0 and keep waiting.
//   - Completion: s_ready=1 in BUSY -> same cycle m_ready[g]=1, m_rdata=s_rdata (combinational);
//     next cycle state=IDLE, grant=0, pointer=g.
//   - Watchdog (TIMEOUT>0): counter increments each BUSY cycle with s_ready=0 (width
//     $clog2(TIMEOUT+1)). On the TIMEOUT-th such cycle: m_ready[g]=1, m_rdata=ERR_DATA,
//     timeout_err=1, then IDLE next cycle with pointer=g. The counter never wraps.
//   - s_ready on the same cycle the watchdog would fire: the normal completion wins, with no
//     timeout_err and s_rdata delivered.
//   - Granted requester drops m_valid while BUSY (protocol abort): next cycle IDLE, grant=0, no
//     m_ready, pointer unchanged; s_valid falls that same cycle via the mux gate.
//   - Reset mid-BUSY: outstanding transfer abandoned without m_ready; all reset values apply next
//     cycle.
//   - m_rdata=0 whenever no m_ready bit is set.
// TESTING
//   1. Req0 write addr 0x0200_0000, wdata 0x0000_00A5, wstrb 4'hF; slave ready 2 cycles after
//      s_valid -> s_valid at t+1, s_wdata=0xA5, m_ready=2'b01 for 1 cycle, grant 01 then 00.
//   2. Both m_valid held, 4 back-to-back transfers -> grant order 01,10,01,10 with one IDLE cycle
//      between each transfer.
//   3. Req1 read (wstrb 0), slave returns s_rdata 0xDEAD_BEEF -> m_ready=2'b10 and
//      m_rdata=0xDEAD_BEEF on that cycle only.
//   4. TIMEOUT=16, slave never ready -> on the 16th BUSY cycle m_ready[g]=1, m_rdata=0xBAD0_BAD0,
//      timeout_err pulse; next contender is then served.
//   5. Reset mid-BUSY -> next cycle s_valid=0, grant=0; on later contention requester 0 wins first.
//   6. s_ready on the 16th BUSY cycle -> timeout_err stays 0 and m_rdata equals s_rdata.

Source files
------------

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: N-way round-robin arbiter that shares one slave between several requesters
// that use the PicoRV32 native memory handshake. A watchdog finishes hung transfers with an
// error word.
//
// Ports
//   clk_i          system clock, rising edge
//   reset_i        synchronous active-high reset
//   m_valid_i      per-requester request, fields held stable until m_ready_o
//   m_ready_o      per-requester completion pulse (one-hot or zero)
//   m_addr_i       packed addresses, requester i at [32*i +: 32]
//   m_wdata_i      packed write data
//   m_wstrb_i      packed byte strobes, 0 = read
//   m_rdata_o      broadcast read data, zero unless an m_ready_o bit is set
//   s_valid_o      request to slave
//   s_ready_i      slave completion
//   s_addr_o       address of granted requester
//   s_wdata_o      write data of granted requester
//   s_wstrb_o      strobes of granted requester
//   s_rdata_i      slave read data, valid with s_ready_i
//   grant_o        registered one-hot owner, 0 when idle
//   timeout_err_o  one-cycle pulse when the watchdog fires
module soc_bus_arbiter #(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hBAD0_BAD0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [NUM_REQ-1:0]    m_valid_i,
    output logic [NUM_REQ-1:0]    m_ready_o,
    input  logic [NUM_REQ*32-1:0] m_addr_i,
    input  logic [NUM_REQ*32-1:0] m_wdata_i,
    input  logic [NUM_REQ*4-1:0]  m_wstrb_i,
    output logic [31:0]           m_rdata_o,
    output logic                  s_valid_o,
    input  logic                  s_ready_i,
    output logic [31:0]           s_addr_o,
    output logic [31:0]           s_wdata_o,
    output logic [3:0]            s_wstrb_o,
    input  logic [31:0]           s_rdata_i,
    output logic [NUM_REQ-1:0]    grant_o,
    output logic                  timeout_err_o
);

    localparam int unsigned PtrW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned TimeoutM1 = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutM1);
    localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PtrW-1:0]    ptr_q, ptr_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic [PtrW-1:0]    owner_idx;
    logic [PtrW-1:0]    pick_idx;
    logic               owner_valid;
    logic               done_ok;
    logic               wd_fire;

    // Slave-side mux: an all-zero grant drives all-zero buses.
    always_comb begin
        owner_idx = '0;
        s_addr_o  = '0;
        s_wdata_o = '0;
        s_wstrb_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_idx = PtrW'(i);
                s_addr_o  = m_addr_i[32*i +: 32];
                s_wdata_o = m_wdata_i[32*i +: 32];
                s_wstrb_o = m_wstrb_i[4*i +: 4];
            end
        end
    end

    // A granted requester that drops m_valid takes s_valid down with it in the same cycle.
    assign owner_valid = (state_q == StBusy) && |(grant_q & m_valid_i);
    assign s_valid_o   = owner_valid;
    assign done_ok     = owner_valid && s_ready_i;
    assign wd_fire     = (TIMEOUT != 0) && owner_valid && !s_ready_i && (cnt_q == CntLast);

    // Round-robin pick: the second loop overrides the first, so the lowest requester above the
    // pointer wins, falling back to the lowest one at or below it (wrap-around).
    always_comb begin
        pick_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (m_valid_i[i] && (32'(i) <= 32'(ptr_q))) begin
                pick_idx = PtrW'(i);
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (m_valid_i[i] && (32'(i) > 32'(ptr_q))) begin
                pick_idx = PtrW'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (|m_valid_i) begin
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    cnt_d             = '0;
                    state_d           = StBusy;
                end
            end
            StBusy: begin
                if (!owner_valid) begin
                    // Protocol abort: release the slave, keep the fairness pointer.
                    state_d = StIdle;
                    grant_d = '0;
                end else if (done_ok || wd_fire) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = owner_idx;
                end else if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // Normal completion takes priority over the watchdog (wd_fire requires !s_ready_i).
    assign m_ready_o     = (done_ok || wd_fire) ? grant_q : '0;
    assign m_rdata_o     = done_ok ? s_rdata_i : (wd_fire ? ERR_DATA : 32'h0);
    assign timeout_err_o = wd_fire;
    assign grant_o       = grant_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            ptr_q   <= PtrW'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
